// File: rtl/inst_encoder.sv
// RV32I instruction encoder feeding a sequential instruction-memory loader.
// Packs fields plus a signed immediate into R/I/S/B/U/J words and flags out-of-range immediates.
module inst_encoder #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  n_words,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        fmt,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic [CNT_W-1:0]    rem_r;
  logic [ADDR_W-1:0]   addr_r;
  logic                out_valid_r;
  logic [31:0]         out_inst_r;
  logic [ADDR_W-1:0]   out_addr_r;
  logic                out_err_r;
  logic [CNT_W-1:0]    err_cnt_r;
  logic                load_s;
  logic                accept_s;
  logic                handoff_s;
  logic [32:0]         enc_s;

  // Returns {range_error, instruction}; a signed value fits N bits when its upper bits are all copies of the sign.
  function automatic logic [32:0] encode(
    input logic [2:0]  f,
    input logic [6:0]  op,
    input logic [4:0]  d,
    input logic [4:0]  s1,
    input logic [4:0]  s2,
    input logic [2:0]  f3,
    input logic [6:0]  f7,
    input logic [31:0] im
  );
    logic [31:0] w;
    logic        e;
    w = 32'h0000_0013;
    e = 1'b1;
    case (f)
      3'd0: begin
        w = {f7, s2, s1, f3, d, op};
        e = 1'b0;
      end
      3'd1: begin
        w = {im[11:0], s1, f3, d, op};
        e = !((im[31:11] == 21'h00_0000) || (im[31:11] == 21'h1F_FFFF));
      end
      3'd2: begin
        w = {im[11:5], s2, s1, f3, im[4:0], op};
        e = !((im[31:11] == 21'h00_0000) || (im[31:11] == 21'h1F_FFFF));
      end
      3'd3: begin
        w = {im[12], im[10:5], s2, s1, f3, im[4:1], im[11], op};
        e = !((im[31:12] == 20'h0_0000) || (im[31:12] == 20'hF_FFFF)) || im[0];
      end
      3'd4: begin
        w = {im[31:12], d, op};
        e = (im[11:0] != 12'h000);
      end
      3'd5: begin
        w = {im[20], im[10:1], im[11], im[19:12], d, op};
        e = !((im[31:20] == 12'h000) || (im[31:20] == 12'hFFF)) || im[0];
      end
      default: begin
        w = 32'h0000_0013;
        e = 1'b1;
      end
    endcase
    return {e, w};
  endfunction

  assign enc_s     = encode(fmt, opcode, rd, rs1, rs2, funct3, funct7, imm);
  assign in_ready  = (state_r == S_RUN) && (!out_valid_r || out_ready);
  assign accept_s  = in_valid && in_ready;
  assign handoff_s = out_valid_r && out_ready;
  assign load_s    = start && ((state_r == S_IDLE) || (state_r == S_DONE));

  assign out_valid = out_valid_r;
  assign out_inst  = out_inst_r;
  assign out_addr  = out_addr_r;
  assign out_err   = out_err_r;
  assign err_cnt   = err_cnt_r;
  assign busy      = (state_r == S_RUN) || (state_r == S_DRAIN);
  assign done      = (state_r == S_DONE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_s = (n_words == {CNT_W{1'b0}}) ? S_DONE : S_RUN;
        end else begin
          state_s = state_r;
        end
      end
      S_RUN: begin
        if (accept_s && (rem_r == CNT_W'(1))) begin
          state_s = S_DRAIN;
        end else begin
          state_s = S_RUN;
        end
      end
      S_DRAIN: begin
        if (handoff_s) begin
          state_s = S_DONE;
        end else begin
          state_s = S_DRAIN;
        end
      end
      default: state_s = S_IDLE;
    endcase
  end

  // Session bookkeeping: next address, words still to accept, saturating error count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r    <= {ADDR_W{1'b0}};
      rem_r     <= {CNT_W{1'b0}};
      err_cnt_r <= {CNT_W{1'b0}};
    end else if (load_s) begin
      addr_r    <= base_addr;
      rem_r     <= n_words;
      err_cnt_r <= {CNT_W{1'b0}};
    end else if (accept_s) begin
      addr_r <= addr_r + ADDR_W'(1);
      rem_r  <= rem_r - CNT_W'(1);
      if (enc_s[32] && (err_cnt_r != {CNT_W{1'b1}})) begin
        err_cnt_r <= err_cnt_r + CNT_W'(1);
      end
    end
  end

  // Single output register; holds while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_inst_r  <= 32'h0000_0000;
      out_addr_r  <= {ADDR_W{1'b0}};
      out_err_r   <= 1'b0;
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      out_inst_r  <= enc_s[31:0];
      out_addr_r  <= addr_r;
      out_err_r   <= enc_s[32];
    end else if (handoff_s) begin
      out_valid_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Randomized self-checking bench for inst_encoder against a queue-based reference model.
module tb_inst_encoder;

  logic        clk = 1'b0;
  logic        rst_n, start, in_valid, in_ready, out_valid, out_ready, out_err, busy, done;
  logic [9:0]  base_addr, n_words, out_addr, err_cnt;
  logic [2:0]  fmt, funct3;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm, out_inst;

  int total = 0;
  int bad = 0;

  inst_encoder dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .n_words(n_words),
    .in_valid(in_valid), .in_ready(in_ready), .fmt(fmt), .opcode(opcode), .rd(rd),
    .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_addr(out_addr),
    .out_err(out_err), .err_cnt(err_cnt), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference encoder: shifts and masks on the field values, signed ranges as integers.
  function automatic logic [32:0] model_enc(input logic [2:0] f, input logic [6:0] op,
      input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
      input logic [6:0] f7, input logic [31:0] im);
    int          s;
    logic [31:0] w;
    logic        e;
    s = $signed(im);
    w = 32'(op);
    e = 1'b0;
    case (f)
      3'd0: w = w | (32'(d) << 7) | (32'(f3) << 12) | (32'(s1) << 15) | (32'(s2) << 20) | (32'(f7) << 25);
      3'd1: begin
        w = w | (32'(d) << 7) | (32'(f3) << 12) | (32'(s1) << 15) | ((im & 32'hFFF) << 20);
        e = (s < -2048) || (s > 2047);
      end
      3'd2: begin
        w = w | ((im & 32'h1F) << 7) | (32'(f3) << 12) | (32'(s1) << 15) | (32'(s2) << 20)
              | (((im >> 5) & 32'h7F) << 25);
        e = (s < -2048) || (s > 2047);
      end
      3'd3: begin
        w = w | (((im >> 11) & 32'h1) << 7) | (((im >> 1) & 32'hF) << 8) | (32'(f3) << 12)
              | (32'(s1) << 15) | (32'(s2) << 20) | (((im >> 5) & 32'h3F) << 25)
              | (((im >> 12) & 32'h1) << 31);
        e = (s < -4096) || (s > 4094) || ((im & 32'h1) != 32'h0);
      end
      3'd4: begin
        w = w | (32'(d) << 7) | (im & 32'hFFFF_F000);
        e = ((im & 32'hFFF) != 32'h0);
      end
      3'd5: begin
        w = w | (32'(d) << 7) | (((im >> 12) & 32'hFF) << 12) | (((im >> 11) & 32'h1) << 20)
              | (((im >> 1) & 32'h3FF) << 21) | (((im >> 20) & 32'h1) << 31);
        e = (s < -1048576) || (s > 1048574) || ((im & 32'h1) != 32'h0);
      end
      default: begin
        w = 32'h0000_0013;
        e = 1'b1;
      end
    endcase
    return {e, w};
  endfunction

  typedef struct {logic [31:0] inst; logic [9:0] addr; logic err;} exp_t;
  exp_t        q[$];
  int          m_acc = 0, m_hand = 0, m_err = 0;
  logic        m_sess = 1'b0;
  logic [9:0]  m_addr = 10'd0;
  logic        hold = 1'b0;
  logic [31:0] p_inst;
  logic [9:0]  p_addr;
  logic        p_err;

  // Compare process: checks every cycle, then advances the model for the coming edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_inst", out_inst, 32'd0);
      chk("rst_out_addr", 32'(out_addr), 32'd0);
      chk("rst_out_err", 32'(out_err), 32'd0);
      chk("rst_err_cnt", 32'(err_cnt), 32'd0);
      chk("rst_busy_done", {busy, done}, 32'd0);
      q.delete();
      m_acc = 0; m_hand = 0; m_err = 0; m_sess = 1'b0; hold = 1'b0;
    end else begin
      chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
      chk("in_ready", 32'(in_ready), 32'((m_acc > 0) && (q.size() == 0 || out_ready)));
      chk("busy", 32'(busy), 32'(m_hand > 0));
      chk("done", 32'(done), 32'(m_sess && m_hand == 0));
      chk("err_cnt", 32'(err_cnt), 32'(m_err));
      if (hold) begin
        chk("stall_inst", out_inst, p_inst);
        chk("stall_addr", 32'(out_addr), 32'(p_addr));
        chk("stall_err", 32'(out_err), 32'(p_err));
      end
      hold = out_valid && !out_ready;
      p_inst = out_inst; p_addr = out_addr; p_err = out_err;
      if (out_valid && out_ready && q.size() != 0) begin
        exp_t x;
        x = q.pop_front();
        chk("out_inst", out_inst, x.inst);
        chk("out_addr", 32'(out_addr), 32'(x.addr));
        chk("out_err", 32'(out_err), 32'(x.err));
        m_hand--;
      end
      if (start && m_hand == 0) begin
        m_sess = 1'b1; m_acc = int'(n_words); m_hand = int'(n_words); m_err = 0; m_addr = base_addr;
      end else if (in_valid && in_ready) begin
        logic [32:0] r;
        exp_t y;
        r = model_enc(fmt, opcode, rd, rs1, rs2, funct3, funct7, imm);
        y.inst = r[31:0]; y.addr = m_addr; y.err = r[32];
        q.push_back(y);
        m_addr = m_addr + 10'd1;
        m_acc--;
        if (r[32] && m_err < 1023) m_err++;
      end
    end
  end

  int bnd[15] = '{2047, 2048, -2048, -2049, 4094, 4095, 4096, -4096, -4098,
                  1048574, 1048576, -1048576, -1048578, 0, 305418240};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_fields();
    int cat;
    fmt = 3'($urandom_range(0, 7));
    opcode = 7'($urandom); rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
    funct3 = 3'($urandom); funct7 = 7'($urandom);
    cat = $urandom_range(0, 4);
    case (cat)
      0: imm = $urandom;
      1: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
      2: imm = bnd[$urandom_range(0, 14)];
      3: imm = (32'($urandom_range(0, 2097151)) - 32'd1048576) & 32'hFFFF_FFFE;
      default: imm = $urandom << 12;
    endcase
  endtask

  task automatic do_start(input logic [9:0] b, input logic [9:0] n);
    in_valid = 1'b0; start = 1'b1; base_addr = b; n_words = n;
    tick();
    start = 1'b0;
  endtask

  task automatic run_session(input logic [9:0] b, input logic [9:0] n, input int pv, input int pr,
                             input int stall);
    int   cyc;
    logic acc;
    do_start(b, n);
    cyc = 0;
    while (!done && cyc < 3000) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      tick();
      if (acc || !in_valid) begin
        in_valid = ($urandom_range(1, 100) <= pv);
        if (in_valid) rand_fields();
      end
      out_ready = (cyc < stall) ? 1'b0 : ($urandom_range(1, 100) <= pr);
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    if (!done) chk("session_timeout", 32'(done), 32'd1);
  endtask

  // Single-word session with hand-computed expectations, including the one-cycle latency.
  task automatic one_word(input string nm, input logic [2:0] f, input logic [6:0] op,
      input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
      input logic [31:0] im, input logic [31:0] exp_inst, input logic exp_err, input int exp_cnt);
    int cyc;
    do_start(10'h20, 10'd1);
    out_ready = 1'b1;
    fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = 7'd0; imm = im;
    in_valid = 1'b1;
    cyc = 0;
    @(negedge clk);
    while (!in_ready && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    chk({nm, "_accept"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk({nm, "_latency"}, 32'(out_valid), 32'd1);
    chk({nm, "_inst"}, out_inst, exp_inst);
    chk({nm, "_err"}, 32'(out_err), 32'(exp_err));
    chk({nm, "_errcnt"}, 32'(err_cnt), 32'(exp_cnt));
    tick();
    chk({nm, "_done"}, 32'(done), 32'd1);
  endtask

  initial begin
    logic [32:0] r;
    int          got, cyc;
    rst_n = 1'b0; start = 1'b0; base_addr = 10'd0; n_words = 10'd0; in_valid = 1'b0;
    out_ready = 1'b1; fmt = 3'd0; opcode = 7'd0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
    funct3 = 3'd0; funct7 = 7'd0; imm = 32'd0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    r = model_enc(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
    chk("model_I", r, {1'b0, 32'hFFF0_0093});
    r = model_enc(3'd2, 7'h23, 5'd0, 5'd3, 5'd2, 3'd2, 7'd0, 32'd8);
    chk("model_S", r, {1'b0, 32'h0021_A423});
    r = model_enc(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC);
    chk("model_B", r, {1'b0, 32'hFE00_0EE3});

    one_word("I_neg1", 3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFF, 32'hFFF0_0093, 1'b0, 0);
    one_word("S_8", 3'd2, 7'h23, 5'd0, 5'd3, 5'd2, 3'd2, 32'd8, 32'h0021_A423, 1'b0, 0);
    one_word("B_m4", 3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0, 0);
    one_word("I_2048", 3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048, 32'h8000_0093, 1'b1, 1);
    one_word("B_3", 3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'd3, 32'h0000_0163, 1'b1, 1);
    one_word("ILL", 3'd6, 7'h33, 5'd4, 5'd5, 5'd6, 3'd1, 32'd0, 32'h0000_0013, 1'b1, 1);

    run_session(10'h3FE, 10'd4, 100, 100, 0);
    in_valid = 1'b1;
    @(negedge clk);
    chk("extra_in_ready", 32'(in_ready), 32'd0);
    tick();
    in_valid = 1'b0;

    run_session(10'h100, 10'd3, 100, 100, 4);

    do_start(10'h010, 10'd5);
    out_ready = 1'b1; in_valid = 1'b1; rand_fields();
    got = 0; cyc = 0;
    while (got < 2 && cyc < 50) begin
      @(negedge clk);
      if (in_valid && in_ready) begin
        got++;
        tick();
        rand_fields();
      end else begin
        tick();
      end
      cyc++;
    end
    rst_n = 1'b0; in_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    do_start(10'h0, 10'd0);
    @(negedge clk);
    chk("n0_done", 32'(done), 32'd1);
    tick();

    for (int s = 0; s < 25; s++) begin
      run_session(10'($urandom), 10'($urandom_range(1, 30)), $urandom_range(30, 100),
                  $urandom_range(30, 100), 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
